id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
//  D->E pipeline stage directly downstream of the register file. Latches the register-file read
//  data RD1/RD2, plus decoded D-stage fields, into E-stage registers. Tracks the destination
//  register and Tnew of the instructions in E and M. Generates the D-stage stall and inserts
//  bubbles. With forwarding built in, it substitutes fresher E/M results for stale RD1/RD2.
// PARAMETERS
//  CTRL_W  16  width of opaque decoded control bundle carried D->E
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high
//  flush       in   1       force bubble into E this edge
//  pc_d        in   32      D-stage PC
//  instr_d     in   32      D-stage instruction
//  rs_d,rt_d   in   5       source register numbers (also drive RF A1/A2)
//  rd1_d,rd2_d in   32      register-file read data for rs_d/rt_d
//  a3_d        in   5       D-stage destination reg (0 = none)
//  tuse_rs_d   in   2       Tuse of rs (3 = not used)
//  tuse_rt_d   in   2       Tuse of rt (3 = not used)
//  tnew_d      in   2       Tnew at E entry (ALU=1, load=2, link=0)
//  ctrl_d      in   CTRL_W  decoded control
//  fwd_e_data  in   32      result held in E (valid when tnew_e==0)
//  fwd_m_data  in   32      result held in M (valid when tnew_m==0)
//  stall_o     out  1       freeze PC and D register; combinational
//  pc_e,instr_e out 32      latched
//  rs_e,rt_e   out  5       latched (for E-stage forwarding downstream)
//  rs_val_e,rt_val_e out 32 latched operands
//  a3_e        out  5       latched dest
//  tnew_e      out  2       latched Tnew
//  a3_m        out  5       tracked M dest
//  tnew_m      out  2       tracked M Tnew
//  ctrl_e      out  CTRL_W  latched control
// BEHAVIOUR
//  - Reset: every registered output is 0; stall_o is 0 while E/M trackers are 0.
//  - Edge priority for the E registers: reset > flush > stall (bubble) > load from D.
//  - Bubble: a3_e=0, tnew_e=0, ctrl_e=0, instr_e=0, rs_e=rt_e=0, vals=0, pc_e=0.
//  - The M tracker advances every non-reset edge: a3_m<=a3_e; tnew_m<=(tnew_e==0)?0:tnew_e-1.
//    Stall never freezes it.
//  - Register number 0 never matches: no stall on it and no forward for it.
//  - Stall, with FWD_EN, is an OR over rs/rt and E/M:
//    (src!=0 && src==a3_x && tuse_src < tnew_x).
//  - Stall, without FWD_EN, is an OR over rs/rt and E/M: (src!=0 && tuse_src!=3 && src==a3_x).
//    The register file's internal W bypass covers W.
//  - Operand select (FWD_EN), per source, first match wins:
//    E match && tnew_e==0 -> fwd_e_data;
//    M match && tnew_m==0 -> fwd_m_data;
//    else rdN_d.
//  - A value latched while the producer has tnew>0 but Tuse allowed issue is stale by design.
//    E-stage forwarding (keyed on rs_e/rt_e) resolves it.
//  - Latency: 1 edge D->E, 1 edge E->M tracker. stall_o is valid in the same cycle as the D inputs.
//  - Simultaneous flush and stall: bubble; stall_o is still driven by hazards.
//  - Reset mid-stall: all registers clear; stall drops the next cycle unless D still hazards
//    on zeroed trackers (it cannot).
// CONFIGURATION
//  - `ID_EX_FWD_EN defined: D-stage forwarding muxes present; Tuse/Tnew stall rule.
//  - `ID_EX_FWD_EN undefined: no muxes (vals = rdN_d); conservative stall rule; fwd_*_data unused.
// STRUCTURE
//  - Package pipe_pkg: TUSE_NONE=2'd3, TNEW_W=2, CTRL_W default, BUBBLE constant, REG_ZERO=5'd0.
//  - Sub-module hazard_ctrl (combinational): computes stall_o and fwd selects from D sources
//    and E/M trackers.
//  - Top holds the E and M registers.
// TESTING
//  1 reset held 2 cycles -> all outputs 0, stall_o=0.
//  2 lw $8 in E (tnew_e=2); D: rs=8, tuse_rs=1 -> stall_o=1 one cycle, E gets bubble (a3_e=0);
//    next cycle tnew_m=1, stall_o=0, D issues.
//  3 FWD_EN, a3_m=5, tnew_m=0, fwd_m_data=0x00001234; D rs=5, rd1_d=0xDEADBEEF
//    -> rs_val_e=0x00001234 after edge.
//  4 a3_e=0, tnew_e=2; D rs=0, tuse=0 -> stall_o=0, rs_val_e=rd1_d.
//  5 flush=1 with valid D -> E bubble; reset asserted during a stall -> all cleared, stall_o=0.
//  6 no FWD_EN, addu $9 in E; D rt=9, tuse_rt=1 -> stall_o=1 for 2 cycles (E then M),
//    then rt_val_e=rd2_d.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the D->E pipeline register and its hazard unit.
// Holds the E-stage bundle layout, the bubble value and the operand-select encoding.
package pipe_pkg;

    localparam int CTRL_W_DEFAULT = 16;
    localparam int TNEW_W = 2;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [31:0]       rs_val;
        logic [31:0]       rt_val;
        logic [4:0]        a3;
        logic [TNEW_W-1:0] tnew;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    // $0 is hard-wired, so it can never be a real dependency.
    function automatic logic reg_hit(
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Combinational hazard unit: D-stage stall and operand forwarding selects.
// Ports: rs_d/rt_d + tuse_*_d (D sources), a3_*/tnew_* (E/M trackers);
// stall, sel_rs, sel_rt out. ID_EX_FWD_EN selects Tuse/Tnew stalls + forwarding.
import pipe_pkg::*;

module hazard_ctrl (
    input  logic [4:0]        rs_d,
    input  logic [4:0]        rt_d,
    input  logic [1:0]        tuse_rs_d,
    input  logic [1:0]        tuse_rt_d,
    input  logic [4:0]        a3_e,
    input  logic [TNEW_W-1:0] tnew_e,
    input  logic [4:0]        a3_m,
    input  logic [TNEW_W-1:0] tnew_m,
    output logic              stall,
    output fwd_sel_e          sel_rs,
    output fwd_sel_e          sel_rt
);

    logic hit_rs_e;
    logic hit_rs_m;
    logic hit_rt_e;
    logic hit_rt_m;

    assign hit_rs_e = reg_hit(rs_d, a3_e);
    assign hit_rs_m = reg_hit(rs_d, a3_m);
    assign hit_rt_e = reg_hit(rt_d, a3_e);
    assign hit_rt_m = reg_hit(rt_d, a3_m);

`ifdef ID_EX_FWD_EN

    // Stall only when the producer's result arrives later than the
    // consumer needs it; everything else is covered by forwarding.
    assign stall = (hit_rs_e && (tuse_rs_d < tnew_e))
                 || (hit_rs_m && (tuse_rs_d < tnew_m))
                 || (hit_rt_e && (tuse_rt_d < tnew_e))
                 || (hit_rt_m && (tuse_rt_d < tnew_m));

    // E is younger than M, so it wins when both match.
    always_comb begin
        sel_rs = FWD_RF;
        if (hit_rs_e && (tnew_e == '0))
            sel_rs = FWD_E;
        else if (hit_rs_m && (tnew_m == '0))
            sel_rs = FWD_M;
    end

    always_comb begin
        sel_rt = FWD_RF;
        if (hit_rt_e && (tnew_e == '0))
            sel_rt = FWD_E;
        else if (hit_rt_m && (tnew_m == '0))
            sel_rt = FWD_M;
    end

`else

    logic unused_tnew;

    // Without forwarding any in-flight producer of a used source blocks D.
    assign stall = ((hit_rs_e || hit_rs_m) && (tuse_rs_d != TUSE_NONE))
                 || ((hit_rt_e || hit_rt_m) && (tuse_rt_d != TUSE_NONE));

    assign sel_rs = FWD_RF;
    assign sel_rt = FWD_RF;
    assign unused_tnew = ^{tnew_e, tnew_m};

`endif

endmodule

// File: rtl/id_ex_pipe.sv
// D->E pipeline register with E/M destination trackers, stall and bubble insertion.
// Ports: D-stage fields in, fwd_*_data in, stall_o out, latched E fields and M tracker out.
// ID_EX_FWD_EN enables the D-stage forwarding muxes and the Tuse/Tnew stall rule.
import pipe_pkg::*;

module id_ex_pipe #(
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [31:0]       pc_d,
    input  logic [31:0]       instr_d,
    input  logic [4:0]        rs_d,
    input  logic [4:0]        rt_d,
    input  logic [31:0]       rd1_d,
    input  logic [31:0]       rd2_d,
    input  logic [4:0]        a3_d,
    input  logic [1:0]        tuse_rs_d,
    input  logic [1:0]        tuse_rt_d,
    input  logic [1:0]        tnew_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [31:0]       fwd_e_data,
    input  logic [31:0]       fwd_m_data,
    output logic              stall_o,
    output logic [31:0]       pc_e,
    output logic [31:0]       instr_e,
    output logic [4:0]        rs_e,
    output logic [4:0]        rt_e,
    output logic [31:0]       rs_val_e,
    output logic [31:0]       rt_val_e,
    output logic [4:0]        a3_e,
    output logic [1:0]        tnew_e,
    output logic [4:0]        a3_m,
    output logic [1:0]        tnew_m,
    output logic [CTRL_W-1:0] ctrl_e
);

    id_ex_t            e_q;
    id_ex_t            d_bus;
    logic [CTRL_W-1:0] ctrl_q;
    logic [4:0]        a3_m_q;
    logic [1:0]        tnew_m_q;
    logic              stall;
    fwd_sel_e          sel_rs;
    fwd_sel_e          sel_rt;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;

    hazard_ctrl u_hazard (
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .tuse_rs_d (tuse_rs_d),
        .tuse_rt_d (tuse_rt_d),
        .a3_e      (e_q.a3),
        .tnew_e    (e_q.tnew),
        .a3_m      (a3_m_q),
        .tnew_m    (tnew_m_q),
        .stall     (stall),
        .sel_rs    (sel_rs),
        .sel_rt    (sel_rt)
    );

`ifdef ID_EX_FWD_EN

    always_comb begin
        rs_val = rd1_d;
        case (sel_rs)
            FWD_E:   rs_val = fwd_e_data;
            FWD_M:   rs_val = fwd_m_data;
            default: rs_val = rd1_d;
        endcase
    end

    always_comb begin
        rt_val = rd2_d;
        case (sel_rt)
            FWD_E:   rt_val = fwd_e_data;
            FWD_M:   rt_val = fwd_m_data;
            default: rt_val = rd2_d;
        endcase
    end

`else

    logic unused_fwd;

    assign rs_val = rd1_d;
    assign rt_val = rd2_d;
    assign unused_fwd = ^{fwd_e_data, fwd_m_data, sel_rs, sel_rt};

`endif

    always_comb begin
        d_bus        = BUBBLE;
        d_bus.pc     = pc_d;
        d_bus.instr  = instr_d;
        d_bus.rs     = rs_d;
        d_bus.rt     = rt_d;
        d_bus.rs_val = rs_val;
        d_bus.rt_val = rt_val;
        d_bus.a3     = a3_d;
        d_bus.tnew   = tnew_d;
    end

    // A stalled D instruction must not enter E, so it gets a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= BUBBLE;
            ctrl_q <= '0;
        end else if (flush || stall) begin
            e_q    <= BUBBLE;
            ctrl_q <= '0;
        end else begin
            e_q    <= d_bus;
            ctrl_q <= ctrl_d;
        end
    end

    // The M tracker always advances; Tnew counts down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            a3_m_q   <= REG_ZERO;
            tnew_m_q <= '0;
        end else begin
            a3_m_q   <= e_q.a3;
            tnew_m_q <= (e_q.tnew == '0) ? '0 : e_q.tnew - 2'd1;
        end
    end

    assign stall_o  = stall;
    assign pc_e     = e_q.pc;
    assign instr_e  = e_q.instr;
    assign rs_e     = e_q.rs;
    assign rt_e     = e_q.rt;
    assign rs_val_e = e_q.rs_val;
    assign rt_val_e = e_q.rt_val;
    assign a3_e     = e_q.a3;
    assign tnew_e   = e_q.tnew;
    assign a3_m     = a3_m_q;
    assign tnew_m   = tnew_m_q;
    assign ctrl_e   = ctrl_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed hazard scenarios plus
// randomized traffic checked each cycle against a timing-level reference model.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] pc_d, instr_d, rd1_d, rd2_d;
    logic [4:0]  rs_d, rt_d, a3_d;
    logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_d;
    logic [15:0] ctrl_d;
    logic [31:0] fwd_e_data, fwd_m_data;
    logic        stall_o;
    logic [31:0] pc_e, instr_e, rs_val_e, rt_val_e;
    logic [4:0]  rs_e, rt_e, a3_e, a3_m;
    logic [1:0]  tnew_e, tnew_m;
    logic [15:0] ctrl_e;

    int total = 0;
    int bad = 0;
    bit armed = 0;

    // model of what sits in E and M
    logic [31:0] me_pc, me_instr, me_rsv, me_rtv;
    logic [4:0]  me_rs, me_rt, me_a3, mm_a3;
    logic [1:0]  me_tnew, mm_tnew;
    logic [15:0] me_ctrl;

    id_ex_pipe dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pc_d(pc_d), .instr_d(instr_d),
        .rs_d(rs_d), .rt_d(rt_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .a3_d(a3_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .tnew_d(tnew_d), .ctrl_d(ctrl_d),
        .fwd_e_data(fwd_e_data), .fwd_m_data(fwd_m_data),
        .stall_o(stall_o), .pc_e(pc_e), .instr_e(instr_e),
        .rs_e(rs_e), .rt_e(rt_e),
        .rs_val_e(rs_val_e), .rt_val_e(rt_val_e),
        .a3_e(a3_e), .tnew_e(tnew_e),
        .a3_m(a3_m), .tnew_m(tnew_m), .ctrl_e(ctrl_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Producer result appears tnew cycles from now; consumer needs it in
    // tuse cycles. Late if it is needed before it exists.
    function automatic bit late(input logic [4:0] src, input logic [1:0] tuse,
                                input logic [4:0] dst, input logic [1:0] tnew);
        if (src == 5'd0 || src != dst) return 0;
`ifdef ID_EX_FWD_EN
        return int'(tuse) < int'(tnew);
`else
        return tuse != 2'd3;
`endif
    endfunction

    function automatic bit model_stall();
        return late(rs_d, tuse_rs_d, me_a3, me_tnew)
            || late(rs_d, tuse_rs_d, mm_a3, mm_tnew)
            || late(rt_d, tuse_rt_d, me_a3, me_tnew)
            || late(rt_d, tuse_rt_d, mm_a3, mm_tnew);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] src,
                                            input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
        if (src != 0 && src == me_a3 && me_tnew == 0) return fwd_e_data;
        if (src != 0 && src == mm_a3 && mm_tnew == 0) return fwd_m_data;
`endif
        return rf;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            me_pc <= 0; me_instr <= 0; me_rs <= 0; me_rt <= 0;
            me_rsv <= 0; me_rtv <= 0; me_a3 <= 0; me_tnew <= 0;
            me_ctrl <= 0; mm_a3 <= 0; mm_tnew <= 0;
        end else begin
            mm_a3 <= me_a3;
            mm_tnew <= (me_tnew > 0) ? 2'(me_tnew - 2'd1) : 2'd0;
            if (flush || model_stall()) begin
                me_pc <= 0; me_instr <= 0; me_rs <= 0; me_rt <= 0;
                me_rsv <= 0; me_rtv <= 0; me_a3 <= 0; me_tnew <= 0;
                me_ctrl <= 0;
            end else begin
                me_pc <= pc_d; me_instr <= instr_d;
                me_rs <= rs_d; me_rt <= rt_d;
                me_rsv <= operand(rs_d, rd1_d);
                me_rtv <= operand(rt_d, rd2_d);
                me_a3 <= a3_d; me_tnew <= tnew_d; me_ctrl <= ctrl_d;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("pc_e", pc_e, me_pc);
            chk("instr_e", instr_e, me_instr);
            chk("rs_e", 32'(rs_e), 32'(me_rs));
            chk("rt_e", 32'(rt_e), 32'(me_rt));
            chk("rs_val_e", rs_val_e, me_rsv);
            chk("rt_val_e", rt_val_e, me_rtv);
            chk("a3_e", 32'(a3_e), 32'(me_a3));
            chk("tnew_e", 32'(tnew_e), 32'(me_tnew));
            chk("a3_m", 32'(a3_m), 32'(mm_a3));
            chk("tnew_m", 32'(tnew_m), 32'(mm_tnew));
            chk("ctrl_e", 32'(ctrl_e), 32'(me_ctrl));
            chk("stall_o", 32'(stall_o), 32'(model_stall()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; pc_d = 0; instr_d = 0; rs_d = 0; rt_d = 0;
        rd1_d = 0; rd2_d = 0; a3_d = 0; tuse_rs_d = 2'd3;
        tuse_rt_d = 2'd3; tnew_d = 0; ctrl_d = 0;
        fwd_e_data = 0; fwd_m_data = 0;
    endtask

    task automatic rst_pulse();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        armed = 1;
        step();
        reset = 0;
        #1;
        // 1: reset state
        chk("t1 stall", 32'(stall_o), 0);
        chk("t1 a3_e", 32'(a3_e), 0);
        chk("t1 tnew_m", 32'(tnew_m), 0);
        chk("t1 pc_e", pc_e, 0);

        // 2: load-use on $8
        a3_d = 8; tnew_d = 2; pc_d = 32'h100;
        step();
        idle();
        rs_d = 8; tuse_rs_d = 1; a3_d = 9; tnew_d = 1;
        pc_d = 32'h104; rd1_d = 32'h11111111;
        #1;
        chk("t2 stall", 32'(stall_o), 1);
        step();
        chk("t2 bubble", 32'(a3_e), 0);
        chk("t2 tnew_m", 32'(tnew_m), 1);
        chk("t2 a3_m", 32'(a3_m), 8);
`ifdef ID_EX_FWD_EN
        chk("t2 release", 32'(stall_o), 0);
`else
        chk("t2 hold", 32'(stall_o), 1);
        step();
        chk("t2 release", 32'(stall_o), 0);
`endif
        step();
        chk("t2 issue a3", 32'(a3_e), 9);
        chk("t2 issue pc", pc_e, 32'h104);
        chk("t2 issue val", rs_val_e, 32'h11111111);

`ifdef ID_EX_FWD_EN
        // 3: forward from M
        rst_pulse();
        a3_d = 5; tnew_d = 1;
        step();
        idle();
        step();
        chk("t3 a3_m", 32'(a3_m), 5);
        chk("t3 tnew_m", 32'(tnew_m), 0);
        rs_d = 5; tuse_rs_d = 0; rd1_d = 32'hDEADBEEF;
        fwd_m_data = 32'h00001234; fwd_e_data = 32'h55555555;
        #1;
        chk("t3 stall", 32'(stall_o), 0);
        step();
        chk("t3 fwd", rs_val_e, 32'h00001234);
`endif

        // 4: $0 never hazards
        rst_pulse();
        tnew_d = 2;
        step();
        idle();
        rs_d = 0; tuse_rs_d = 0; rd1_d = 32'hCAFEF00D;
        #1;
        chk("t4 stall", 32'(stall_o), 0);
        step();
        chk("t4 val", rs_val_e, 32'hCAFEF00D);

        // 5: flush, then reset during a stall
        rst_pulse();
        a3_d = 7; pc_d = 32'h200; instr_d = 32'h1234;
        ctrl_d = 16'hFFFF; flush = 1;
        step();
        chk("t5 flush a3", 32'(a3_e), 0);
        chk("t5 flush pc", pc_e, 0);
        chk("t5 flush ctrl", 32'(ctrl_e), 0);
        idle();
        a3_d = 8; tnew_d = 2;
        step();
        idle();
        rs_d = 8; tuse_rs_d = 0;
        #1;
        chk("t5 stall", 32'(stall_o), 1);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("t5 rst a3_e", 32'(a3_e), 0);
        chk("t5 rst a3_m", 32'(a3_m), 0);
        chk("t5 rst stall", 32'(stall_o), 0);

`ifndef ID_EX_FWD_EN
        // 6: conservative stall on ALU producer
        rst_pulse();
        a3_d = 9; tnew_d = 1;
        step();
        idle();
        rt_d = 9; tuse_rt_d = 1; rd2_d = 32'h0000600D;
        #1;
        chk("t6 stall E", 32'(stall_o), 1);
        step();
        chk("t6 stall M", 32'(stall_o), 1);
        step();
        chk("t6 release", 32'(stall_o), 0);
        step();
        chk("t6 val", rt_val_e, 32'h0000600D);
`endif

        // randomized traffic
        rst_pulse();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            pc_d = $urandom;
            instr_d = $urandom;
            rs_d = 5'($urandom_range(0, 3));
            rt_d = 5'($urandom_range(0, 3));
            a3_d = 5'($urandom_range(0, 3));
            tuse_rs_d = 2'($urandom_range(0, 3));
            tuse_rt_d = 2'($urandom_range(0, 3));
            tnew_d = 2'($urandom_range(0, 2));
            rd1_d = $urandom;
            rd2_d = $urandom;
            ctrl_d = 16'($urandom);
            fwd_e_data = $urandom;
            fwd_m_data = $urandom;
            step();
        end
        idle();
        reset = 0;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
